mem_stage: RTL and testbench

Pipeline MEM stage: consumes the EX stage's registered outputs (ALU result, store data, destination register, MEM/WB control), performs at most one data-memory access per instruction over a request/acknowledge bus, and presents the MEM/WB register contents to the write-back stage. It stalls the upstream pipeline while a memory access is outstanding. It also flags misaligned, illegal or timed-out accesses.

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/mem_wb_reg.sv | 44 ++++
 rtl/mem_stage.sv | 174 +++++++++++++++++
 tb/tb_mem_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline stages: control-bit positions inside
// the MEM and WB control fields, the MEM-stage state encoding, the MEM/WB
// register payload, and small decode helpers.
package cpu_pkg;

  // Bit positions inside MEMControl: [1] MemRead, [0] MemWrite
  localparam int unsigned MEMCTL_READ  = 1;
  localparam int unsigned MEMCTL_WRITE = 0;

  // Bit positions inside WBControl: [1] MemToReg, [0] RegWrite
  localparam int unsigned WBCTL_MEMTOREG = 1;
  localparam int unsigned WBCTL_REGWRITE = 0;

  // Width of the wait counter; large enough for MAX_WAIT up to 255
  localparam int unsigned WAIT_CNT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  // Payload carried by the MEM/WB register (valid travels separately)
  typedef struct packed {
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [4:0]  rd;
    logic [1:0]  wb_ctl;
    logic        err;
  } mem_wb_t;

  // True when the instruction touches data memory at all
  function automatic logic is_mem_op(input logic [1:0] mem_ctl);
    return |mem_ctl;
  endfunction

  // A memory op that must not reach the bus: both read and write requested,
  // or an address that is not word aligned
  function automatic logic is_bad_access(input logic [1:0] mem_ctl,
                                         input logic [1:0] addr_lo);
    return (&mem_ctl) || (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A load writes the whole payload and raises
// valid for one cycle; without a load, valid and err fall back to 0 while
// the data fields keep their last value. kill_regwrite clears RegWrite so a
// faulting instruction cannot update the register file.
import cpu_pkg::*;

module mem_wb_reg (
  input  logic    clk,
  input  logic    srst,
  input  logic    load,
  input  logic    kill_regwrite,
  input  mem_wb_t d,
  output logic    valid,
  output mem_wb_t q
);

  logic    valid_reg;
  mem_wb_t q_reg;
  mem_wb_t d_next;

  // Apply the RegWrite kill to the incoming payload
  always_comb begin
    d_next = d;
    d_next.wb_ctl[WBCTL_REGWRITE] = d.wb_ctl[WBCTL_REGWRITE] & ~kill_regwrite;
  end

  // Register the payload on load; otherwise drop the single-cycle flags
  always_ff @(posedge clk) begin
    if (srst) begin
      valid_reg <= 1'b0;
      q_reg     <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      q_reg     <= d_next;
    end else begin
      valid_reg <= 1'b0;
      q_reg.err <= 1'b0;
    end
  end

  assign valid = valid_reg;
  assign q     = q_reg;

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage. Non-memory instructions pass straight to the MEM/WB
// register in one cycle. A legal load/store is latched in IDLE, issued on a
// registered request/acknowledge bus, and held in WAIT until Mem_Ack or a
// timeout; the upstream stage is stalled meanwhile. Misaligned or
// read+write accesses and timeouts complete with an error pulse and
// RegWrite suppressed.
import cpu_pkg::*;

module mem_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Valid_In,
  input  logic [31:0] Result_In,
  input  logic [31:0] Data_In,
  input  logic [4:0]  Rd_In,
  input  logic [1:0]  MEMControl_In,
  input  logic [1:0]  WBControl_In,
  output logic        Stall_Out,
  output logic        Mem_Req,
  output logic        Mem_We,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_WData,
  input  logic [31:0] Mem_RData,
  input  logic        Mem_Ack,
  output logic        Valid_Out,
  output logic [31:0] ReadData_Out,
  output logic [31:0] ALUResult_Out,
  output logic [4:0]  Rd_Out,
  output logic [1:0]  WBControl_Out,
  output logic        Err_Out
);

  // Counter value of the last WAIT cycle before giving up on the ack
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MAX_WAIT - 1);

  mem_state_e            state_reg;
  logic [WAIT_CNT_W-1:0] wait_cnt_reg;
  logic                  mem_req_reg;
  logic                  mem_we_reg;
  logic [31:0]           mem_addr_reg;
  logic [31:0]           mem_wdata_reg;
  logic [4:0]            rd_hold_reg;
  logic [1:0]            wb_hold_reg;

  logic    mem_op;
  logic    bad_access;
  logic    start_access;
  logic    wait_last;
  logic    wb_load;
  logic    wb_kill;
  mem_wb_t wb_d;
  logic    wb_valid;
  mem_wb_t wb_q;

  // Decode the incoming instruction and the wait-limit condition
  always_comb begin
    mem_op       = Valid_In && is_mem_op(MEMControl_In);
    bad_access   = mem_op && is_bad_access(MEMControl_In, Result_In[1:0]);
    start_access = mem_op && !bad_access;
    wait_last    = (wait_cnt_reg == WAIT_LAST);
  end

  // Hold upstream while a legal access is being captured or is outstanding;
  // release in the completing cycle so upstream advances on that edge
  always_comb begin
    Stall_Out = 1'b0;
    unique case (state_reg)
      IDLE:    Stall_Out = start_access;
      WAIT:    Stall_Out = !(Mem_Ack || wait_last);
      default: Stall_Out = 1'b0;
    endcase
  end

  // Select what, if anything, enters the MEM/WB register this cycle
  always_comb begin
    wb_load = 1'b0;
    wb_kill = 1'b0;
    wb_d    = '0;
    unique case (state_reg)
      IDLE: begin
        // Non-memory ops and rejected accesses complete immediately
        if (Valid_In && !start_access) begin
          wb_load         = 1'b1;
          wb_kill         = bad_access;
          wb_d.alu_result = Result_In;
          wb_d.rd         = Rd_In;
          wb_d.wb_ctl     = WBControl_In;
          wb_d.err        = bad_access;
        end
      end
      WAIT: begin
        // An ack in the final wait cycle still counts as success
        if (Mem_Ack || wait_last) begin
          wb_load         = 1'b1;
          wb_kill         = !Mem_Ack;
          wb_d.alu_result = mem_addr_reg;
          wb_d.rd         = rd_hold_reg;
          wb_d.wb_ctl     = wb_hold_reg;
          wb_d.err        = !Mem_Ack;
          wb_d.read_data  = (Mem_Ack && !mem_we_reg) ? Mem_RData : 32'h0;
        end
      end
      default: begin
        wb_load = 1'b0;
      end
    endcase
  end

  // Access FSM: latch and issue the bus request, count wait cycles, retire
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      rd_hold_reg   <= '0;
      wb_hold_reg   <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (start_access) begin
            state_reg     <= WAIT;
            wait_cnt_reg  <= '0;
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= MEMControl_In[MEMCTL_WRITE];
            mem_addr_reg  <= {Result_In[31:2], 2'b00};
            mem_wdata_reg <= Data_In;
            rd_hold_reg   <= Rd_In;
            wb_hold_reg   <= WBControl_In;
          end
        end
        WAIT: begin
          if (Mem_Ack || wait_last) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            mem_req_reg  <= 1'b0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg   <= IDLE;
          mem_req_reg <= 1'b0;
        end
      endcase
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk           (Clk),
    .srst          (Rst),
    .load          (wb_load),
    .kill_regwrite (wb_kill),
    .d             (wb_d),
    .valid         (wb_valid),
    .q             (wb_q)
  );

  assign Mem_Req       = mem_req_reg;
  assign Mem_We        = mem_we_reg;
  assign Mem_Addr      = mem_addr_reg;
  assign Mem_WData     = mem_wdata_reg;
  assign Valid_Out     = wb_valid;
  assign ReadData_Out  = wb_q.read_data;
  assign ALUResult_Out = wb_q.alu_result;
  assign Rd_Out        = wb_q.rd;
  assign WBControl_Out = wb_q.wb_ctl;
  assign Err_Out       = wb_q.err;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (MAX_WAIT = 4): a vector table for the
// single-cycle paths, then hand-written load/store/timeout/reset sequences.
module tb_mem_stage;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Valid_In;
  logic [31:0] Result_In;
  logic [31:0] Data_In;
  logic [4:0]  Rd_In;
  logic [1:0]  MEMControl_In;
  logic [1:0]  WBControl_In;
  logic        Stall_Out;
  logic        Mem_Req;
  logic        Mem_We;
  logic [31:0] Mem_Addr;
  logic [31:0] Mem_WData;
  logic [31:0] Mem_RData;
  logic        Mem_Ack;
  logic        Valid_Out;
  logic [31:0] ReadData_Out;
  logic [31:0] ALUResult_Out;
  logic [4:0]  Rd_Out;
  logic [1:0]  WBControl_Out;
  logic        Err_Out;

  int n_vec = 0;
  int n_mis = 0;

  mem_stage #(.MAX_WAIT(4)) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .Valid_In      (Valid_In),
    .Result_In     (Result_In),
    .Data_In       (Data_In),
    .Rd_In         (Rd_In),
    .MEMControl_In (MEMControl_In),
    .WBControl_In  (WBControl_In),
    .Stall_Out     (Stall_Out),
    .Mem_Req       (Mem_Req),
    .Mem_We        (Mem_We),
    .Mem_Addr      (Mem_Addr),
    .Mem_WData     (Mem_WData),
    .Mem_RData     (Mem_RData),
    .Mem_Ack       (Mem_Ack),
    .Valid_Out     (Valid_Out),
    .ReadData_Out  (ReadData_Out),
    .ALUResult_Out (ALUResult_Out),
    .Rd_Out        (Rd_Out),
    .WBControl_Out (WBControl_Out),
    .Err_Out       (Err_Out)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        vin;
    logic [31:0] res;
    logic [4:0]  rd;
    logic [1:0]  mctl;
    logic [1:0]  wctl;
    logic        e_stall;
    logic        e_vo;
    logic        e_err;
    logic        chk_data;
    logic [31:0] e_alu;
    logic [4:0]  e_rd;
    logic [1:0]  e_wb;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Issue one memory op from IDLE and follow it to completion.
  // ack_after: WAIT cycle (1-based) in which Mem_Ack pulses; 0 = never.
  task automatic run_mem(input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] mctl, input logic [1:0] wctl,
                         input logic [4:0] rd, input int ack_after,
                         input logic [31:0] rdata,
                         output int stalls, output int reqs);
    bit done = 0;
    stalls = 0;
    reqs   = 0;
    Valid_In      = 1'b1;
    Result_In     = addr;
    Data_In       = data;
    Rd_In         = rd;
    MEMControl_In = mctl;
    WBControl_In  = wctl;
    #1;
    if (Stall_Out) stalls++;
    tick();
    check("req_issued", Mem_Req, 1'b1);
    check("req_we", Mem_We, mctl[0]);
    check("req_addr", Mem_Addr, addr);
    check("req_wdata", Mem_WData, data);
    check("valid_low_in_wait", Valid_Out, 1'b0);
    for (int k = 1; k <= 20 && !done; k++) begin
      if (k == ack_after) begin
        Mem_Ack   = 1'b1;
        Mem_RData = rdata;
      end
      #1;
      if (Stall_Out) stalls++;
      if (Mem_Req) reqs++;
      if (k == ack_after) check("ack_cycle_stall", Stall_Out, 1'b0);
      tick();
      Mem_Ack   = 1'b0;
      Mem_RData = 32'h0;
      if (Valid_Out) done = 1;
    end
    Valid_In      = 1'b0;
    MEMControl_In = 2'b00;
    if (!done) check("mem_op_completed", 1'b0, 1'b1);
  endtask

  initial begin
    int stalls;
    int reqs;

    vecs[0] = '{1'b1, 32'h0000_1234, 5'd5,  2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_1234, 5'd5,  2'b01};
    vecs[1] = '{1'b1, 32'hFFFF_FFFF, 5'd31, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 5'd31, 2'b00};
    vecs[2] = '{1'b1, 32'h0000_0102, 5'd7,  2'b10, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0102, 5'd7,  2'b10};
    vecs[3] = '{1'b1, 32'h0000_0203, 5'd8,  2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0203, 5'd8,  2'b00};
    vecs[4] = '{1'b1, 32'h0000_0100, 5'd9,  2'b11, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 5'd9,  2'b00};
    vecs[5] = '{1'b0, 32'h0000_0400, 5'd1,  2'b10, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         5'd0,  2'b00};
    vecs[6] = '{1'b1, 32'h0000_0000, 5'd0,  2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,         5'd0,  2'b11};

    Rst = 1'b1; Valid_In = 1'b0; Result_In = '0; Data_In = '0; Rd_In = '0;
    MEMControl_In = '0; WBControl_In = '0; Mem_RData = '0; Mem_Ack = 1'b0;
    tick();
    tick();
    check("rst_valid", Valid_Out, 1'b0);
    check("rst_err", Err_Out, 1'b0);
    check("rst_req", Mem_Req, 1'b0);
    check("rst_we", Mem_We, 1'b0);
    check("rst_addr", Mem_Addr, 32'h0);
    check("rst_wdata", Mem_WData, 32'h0);
    check("rst_rdata", ReadData_Out, 32'h0);
    check("rst_alu", ALUResult_Out, 32'h0);
    check("rst_rd", Rd_Out, 5'd0);
    check("rst_wb", WBControl_Out, 2'b00);
    check("rst_stall", Stall_Out, 1'b0);
    Rst = 1'b0;
    $display("reset sequence done");

    foreach (vecs[i]) begin
      Valid_In      = vecs[i].vin;
      Result_In     = vecs[i].res;
      Rd_In         = vecs[i].rd;
      MEMControl_In = vecs[i].mctl;
      WBControl_In  = vecs[i].wctl;
      #1;
      check($sformatf("v%0d_stall", i), Stall_Out, vecs[i].e_stall);
      tick();
      check($sformatf("v%0d_valid", i), Valid_Out, vecs[i].e_vo);
      check($sformatf("v%0d_err", i), Err_Out, vecs[i].e_err);
      check($sformatf("v%0d_req", i), Mem_Req, 1'b0);
      if (vecs[i].chk_data) begin
        check($sformatf("v%0d_alu", i), ALUResult_Out, vecs[i].e_alu);
        check($sformatf("v%0d_rd", i), Rd_Out, vecs[i].e_rd);
        check($sformatf("v%0d_wb", i), WBControl_Out, vecs[i].e_wb);
        check($sformatf("v%0d_rdata", i), ReadData_Out, 32'h0);
      end
      $display("vector %0d applied: res=%h mctl=%b", i, vecs[i].res, vecs[i].mctl);
    end
    Valid_In = 1'b0;
    MEMControl_In = 2'b00;

    // Load, ack in the third WAIT cycle
    run_mem(32'h100, 32'h0, 2'b10, 2'b11, 5'd9, 3, 32'hDEAD_BEEF, stalls, reqs);
    check("load_stalls", stalls, 3);
    check("load_valid", Valid_Out, 1'b1);
    check("load_err", Err_Out, 1'b0);
    check("load_rdata", ReadData_Out, 32'hDEAD_BEEF);
    check("load_wb", WBControl_Out, 2'b11);
    check("load_rd", Rd_Out, 5'd9);
    check("load_alu", ALUResult_Out, 32'h100);
    check("load_req_drop", Mem_Req, 1'b0);
    $display("load sequence done: stalls=%0d", stalls);

    // Store issued back-to-back, ack in the first WAIT cycle
    run_mem(32'h200, 32'hA5A5_A5A5, 2'b01, 2'b00, 5'd4, 1, 32'h1111_1111, stalls, reqs);
    check("store_stalls", stalls, 1);
    check("store_valid", Valid_Out, 1'b1);
    check("store_err", Err_Out, 1'b0);
    check("store_rdata", ReadData_Out, 32'h0);
    check("store_req_drop", Mem_Req, 1'b0);
    tick();
    check("store_valid_pulse", Valid_Out, 1'b0);
    $display("store sequence done: stalls=%0d", stalls);

    // No ack: timeout after MAX_WAIT request cycles
    run_mem(32'h300, 32'h0, 2'b10, 2'b11, 5'd3, 0, 32'h0, stalls, reqs);
    check("to_req_cycles", reqs, 4);
    check("to_stalls", stalls, 4);
    check("to_valid", Valid_Out, 1'b1);
    check("to_err", Err_Out, 1'b1);
    check("to_wb", WBControl_Out, 2'b10);
    check("to_rdata", ReadData_Out, 32'h0);
    check("to_req_drop", Mem_Req, 1'b0);
    tick();
    check("to_err_pulse", Err_Out, 1'b0);
    $display("timeout sequence done: reqs=%0d", reqs);

    // Ack in the last wait cycle wins over the timeout
    run_mem(32'h304, 32'h0, 2'b10, 2'b01, 5'd6, 4, 32'h0BAD_F00D, stalls, reqs);
    check("late_ack_err", Err_Out, 1'b0);
    check("late_ack_rdata", ReadData_Out, 32'h0BAD_F00D);
    check("late_ack_wb", WBControl_Out, 2'b01);
    check("late_ack_stalls", stalls, 4);
    $display("ack-at-limit sequence done");

    // Reset during WAIT, then a stray ack
    Valid_In = 1'b1; Result_In = 32'h500; Rd_In = 5'd2;
    MEMControl_In = 2'b10; WBControl_In = 2'b11;
    tick();
    Valid_In = 1'b0; MEMControl_In = 2'b00;
    tick();
    check("rw_req_before", Mem_Req, 1'b1);
    Rst = 1'b1;
    tick();
    check("rw_req", Mem_Req, 1'b0);
    check("rw_addr", Mem_Addr, 32'h0);
    check("rw_valid", Valid_Out, 1'b0);
    check("rw_wb", WBControl_Out, 2'b00);
    Rst = 1'b0;
    Mem_Ack = 1'b1; Mem_RData = 32'h7777_7777;
    #1;
    check("rw_stall", Stall_Out, 1'b0);
    tick();
    Mem_Ack = 1'b0; Mem_RData = 32'h0;
    check("rw_ack_valid", Valid_Out, 1'b0);
    check("rw_ack_rdata", ReadData_Out, 32'h0);
    check("rw_ack_req", Mem_Req, 1'b0);
    $display("reset-in-wait sequence done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
